matrix_mem_responder: RTL and testbench

//  Word-addressed scratchpad memory acting as the responder (slave) end of the
//  mem_operation/mem_opdone request protocol used by the accelerator masters.

---
 rtl/matrix_mem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_matrix_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mem_responder.sv
// Word-addressed scratchpad serving one mem_operation/mem_opdone master request at a time
// with configurable wait states, plus a lower-priority host port for preload and readback.
module matrix_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            mem_operation,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  mem_opdone,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_ack,
    output logic                  busy,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_HACK = 2'd3
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;
    localparam logic [1:0] OP_RSVD  = 2'b10;
    localparam logic [3:0] C_WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam int         DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_oor;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_h_we;
    logic [ADDR_WIDTH-1:0] r_h_addr;
    logic [DATA_WIDTH-1:0] r_h_wdata;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic                  r_opdone;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic                  r_host_ack;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_req;
    logic                  w_oor_in;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_rd_oor;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    assign w_req     = (mem_operation == OP_READ) || (mem_operation == OP_WRITE);
    assign w_oor_in  = |addr_i[31:ADDR_WIDTH];
    assign w_rd_data = r_mem[w_rd_addr];

    // Master read address: live inputs when responding straight from IDLE, latched otherwise
    always_comb begin
        w_rd_addr = r_addr;
        w_rd_oor  = r_oor;
        if (r_state == S_IDLE) begin
            w_rd_addr = addr_i[ADDR_WIDTH-1:0];
            w_rd_oor  = w_oor_in;
        end else begin
            w_rd_addr = r_addr;
            w_rd_oor  = r_oor;
        end
    end

    // Single write port: master commits in RESP (in-range only), host commits in HACK
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_addr;
        w_mem_wdata = r_wdata;
        case (r_state)
            S_RESP: begin
                w_mem_we    = r_we & ~r_oor;
                w_mem_waddr = r_addr;
                w_mem_wdata = r_wdata;
            end
            S_HACK: begin
                w_mem_we    = r_h_we;
                w_mem_waddr = r_h_addr;
                w_mem_wdata = r_h_wdata;
            end
            default: begin
                w_mem_we    = 1'b0;
                w_mem_waddr = r_addr;
                w_mem_wdata = r_wdata;
            end
        endcase
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Request FSM with registered handshake, data and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_oor        <= 1'b0;
            r_wdata      <= '0;
            r_h_we       <= 1'b0;
            r_h_addr     <= '0;
            r_h_wdata    <= '0;
            r_data_o     <= '0;
            r_opdone     <= 1'b0;
            r_host_rdata <= '0;
            r_host_ack   <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_opdone   <= 1'b0;
                    r_host_ack <= 1'b0;
                    if (w_req) begin
                        r_we    <= mem_operation[1];
                        r_addr  <= addr_i[ADDR_WIDTH-1:0];
                        r_oor   <= w_oor_in;
                        r_wdata <= data_i;
                        r_busy  <= 1'b1;
                        if (w_oor_in) begin
                            r_err <= 1'b1;
                        end
                        if (LATENCY == 0) begin
                            r_state  <= S_RESP;
                            r_opdone <= 1'b1;
                            if (!mem_operation[1]) begin
                                r_data_o <= w_rd_oor ? '0 : w_rd_data;
                            end
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= C_WAIT_INIT;
                        end
                    end else if (host_req) begin
                        r_state    <= S_HACK;
                        r_h_we     <= host_we;
                        r_h_addr   <= host_addr;
                        r_h_wdata  <= host_wdata;
                        r_host_ack <= 1'b1;
                        r_busy     <= 1'b1;
                        if (!host_we) begin
                            r_host_rdata <= r_mem[host_addr];
                        end
                        if (mem_operation == OP_RSVD) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_busy <= 1'b0;
                        if (mem_operation == OP_RSVD) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_RESP;
                        r_opdone <= 1'b1;
                        if (!r_we) begin
                            r_data_o <= w_rd_oor ? '0 : w_rd_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_opdone <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_HACK: begin
                    r_host_ack <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_opdone   <= 1'b0;
                    r_host_ack <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign data_o     = r_data_o;
    assign mem_opdone = r_opdone;
    assign host_rdata = r_host_rdata;
    assign host_ack   = r_host_ack;
    assign busy       = r_busy;
    assign err_o      = r_err;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed bench for matrix_mem_responder (LATENCY=2): handshake timing, host port,
// burst reads, arbitration, error flag and reset during a pending write.
module tb_matrix_mem_responder;

    logic        clk;
    logic        reset_n;
    logic [1:0]  mem_operation;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        mem_opdone;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic        busy;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    matrix_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_operation (mem_operation),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .data_o        (data_o),
        .mem_opdone    (mem_opdone),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_rdata    (host_rdata),
        .host_ack      (host_ack),
        .busy          (busy),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Master transaction; returns response data and checks the LATENCY+1 handshake delay
    task automatic mst(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        int lat;
        lat = -1;
        mem_operation = op;
        addr_i        = a;
        data_i        = d;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (mem_opdone) begin
                lat = i;
                break;
            end
        end
        rd = data_o;
        mem_operation = 2'b00;
        chk({tag, "_lat"}, lat, 32'd3);
        tick();
    endtask

    task automatic hst(input string tag, input logic we, input logic [7:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        int lat;
        lat = -1;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (host_ack) begin
                lat = i;
                break;
            end
        end
        rd = host_rdata;
        host_req = 1'b0;
        chk({tag, "_lat"}, lat, 32'd1);
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_burst [4];
        int          t_done;
        int          t_ack;
        int          gap;

        exp_burst[0] = 32'd3; exp_burst[1] = 32'd2; exp_burst[2] = 32'd2; exp_burst[3] = 32'd3;
        reset_n = 1'b0; mem_operation = 2'b00; addr_i = 32'd0; data_i = 32'd0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'd0; host_wdata = 32'd0;
        tick(); tick();
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_opdone", {31'd0, mem_opdone}, 32'd0);
        chk("rst_host_rdata", host_rdata, 32'd0);
        chk("rst_host_ack", {31'd0, host_ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Host preload then cycle-exact master read
        hst("hw5", 1'b1, 8'd5, 32'd7, rd);
        mem_operation = 2'b01; addr_i = 32'd5;
        tick();
        chk("lat_t1_opdone", {31'd0, mem_opdone}, 32'd0);
        chk("lat_t1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("lat_t2_opdone", {31'd0, mem_opdone}, 32'd0);
        tick();
        chk("lat_t3_opdone", {31'd0, mem_opdone}, 32'd1);
        chk("lat_t3_data", data_o, 32'd7);
        mem_operation = 2'b00;
        tick();
        chk("lat_t4_opdone", {31'd0, mem_opdone}, 32'd0);
        chk("lat_t4_busy", {31'd0, busy}, 32'd0);

        // Master write, master readback, host readback
        mst("mw4", 2'b11, 32'd4, 32'hDEADBEEF, rd);
        mst("mr4", 2'b01, 32'd4, 32'd0, rd);
        chk("mr4_data", rd, 32'hDEADBEEF);
        hst("hr4", 1'b0, 8'd4, 32'd0, rd);
        chk("hr4_data", rd, 32'hDEADBEEF);

        // Burst with op held and address advanced on each opdone
        for (int k = 0; k < 4; k++) hst("pre", 1'b1, 8'(k), exp_burst[k], rd);
        mem_operation = 2'b01; addr_i = 32'd0;
        for (int k = 0; k < 4; k++) begin
            gap = -1;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (mem_opdone) begin
                    gap = i;
                    break;
                end
            end
            chk("burst_gap", gap, (k == 0) ? 32'd3 : 32'd4);
            chk("burst_data", data_o, exp_burst[k]);
            if (k == 3) mem_operation = 2'b00;
            else        addr_i = 32'(k + 1);
        end
        tick();

        // Simultaneous master read and host read: master first, host right after
        mem_operation = 2'b01; addr_i = 32'd4;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
        t_done = -1; t_ack = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (mem_opdone) begin
                t_done = i;
                chk("arb_mdata", data_o, 32'hDEADBEEF);
                mem_operation = 2'b00;
            end
            if (host_ack) begin
                t_ack = i;
                chk("arb_hdata", host_rdata, 32'd7);
                host_req = 1'b0;
                break;
            end
        end
        chk("arb_t_opdone", t_done, 32'd3);
        chk("arb_t_ack", t_ack, 32'd5);
        tick();

        // Out-of-range read
        chk("err_pre", {31'd0, err_o}, 32'd0);
        mst("oor", 2'b01, 32'h100, 32'd0, rd);
        chk("oor_data", rd, 32'd0);
        chk("oor_err", {31'd0, err_o}, 32'd1);

        // Reserved op: no handshake, sticky error
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        chk("rsvd_err_clr", {31'd0, err_o}, 32'd0);
        mem_operation = 2'b10; addr_i = 32'd1; t_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_opdone) t_done++;
        end
        mem_operation = 2'b00;
        chk("rsvd_no_opdone", t_done, 32'd0);
        chk("rsvd_err", {31'd0, err_o}, 32'd1);
        chk("rsvd_busy", {31'd0, busy}, 32'd0);

        // Reset while a write is waiting: it must never commit
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        hst("hw9", 1'b1, 8'd9, 32'd1, rd);
        mst("mr5b", 2'b01, 32'd5, 32'd0, rd);
        mem_operation = 2'b11; addr_i = 32'd9; data_i = 32'h55;
        tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_opdone", {31'd0, mem_opdone}, 32'd0);
        chk("mid_rst_data", data_o, 32'd0);
        mem_operation = 2'b00;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        mst("mr9", 2'b01, 32'd9, 32'd0, rd);
        chk("mr9_data", rd, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
